// File: rtl/matvec_acc_if.sv
// Upstream-memory and result bus of the matrix-vector accumulator.
// The slave side is the accumulator; the master side owns the memories and consumes results.
interface matvec_acc_if #(
    parameter int NROW     = 16,
    parameter int NCOL     = 16,
    parameter int BITWIDTH = 18
);
    logic                       start;
    logic [NROW*BITWIDTH-1:0]   weightRow;
    logic [BITWIDTH-1:0]        inputVector;
    logic [NROW*BITWIDTH-1:0]   biasVector;
    logic [$clog2(NCOL)-1:0]    colAddress;
    logic                       busy;
    logic                       dataReady;
    logic [NROW*BITWIDTH-1:0]   outputVector;

    modport slave (
        input  start, weightRow, inputVector, biasVector,
        output colAddress, busy, dataReady, outputVector
    );

    modport master (
        output start, weightRow, inputVector, biasVector,
        input  colAddress, busy, dataReady, outputVector
    );
endinterface

// File: rtl/matvec_acc.sv
// Fixed-point y = W*x + b; each multiplier lane serves DSP48_PER_ROW rows over successive passes.
// state | meaning
// IDLE  | waiting for start, colAddress parked at 0
// CALC  | sweeping columns, DSP48_PER_ROW passes of NCOL cycles
// DONE  | one cycle, outputVector freshly updated, dataReady high
module matvec_acc #(
    parameter int NROW          = 16,
    parameter int NCOL          = 16,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int DSP48_PER_ROW = 2
) (
    input  logic        clk,
    input  logic        reset,
    matvec_acc_if.slave bus
);
    localparam int BITWIDTH     = QN + QM + 1;
    localparam int N_DSP48      = NROW / DSP48_PER_ROW;
    localparam int CW           = $clog2(NCOL);
    localparam int PW           = (DSP48_PER_ROW > 1) ? $clog2(DSP48_PER_ROW) : 1;
    localparam int ACC_BITWIDTH = 2 * BITWIDTH + CW + 1;

    localparam logic signed [ACC_BITWIDTH-1:0] RND_HALF = ACC_BITWIDTH'(1) << (QM - 1);
    localparam logic signed [ACC_BITWIDTH-1:0] SAT_MAX  =
        (ACC_BITWIDTH'(1) << (BITWIDTH - 1)) - ACC_BITWIDTH'(1);
    localparam logic signed [ACC_BITWIDTH-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]              col;
    logic [PW-1:0]              row_mux;
    logic                       col_last;
    logic                       pass_last;
    logic signed [BITWIDTH-1:0] x;

    logic signed [ACC_BITWIDTH-1:0] acc      [N_DSP48];
    logic signed [ACC_BITWIDTH-1:0] lane_sum [N_DSP48];
    logic signed [BITWIDTH-1:0]     lane_sat [N_DSP48];

    logic [NROW*BITWIDTH-1:0] staging;
    logic [NROW*BITWIDTH-1:0] staging_next;
    logic [NROW*BITWIDTH-1:0] out_vec;

    assign col_last  = (col == CW'(NCOL - 1));
    assign pass_last = (row_mux == PW'(DSP48_PER_ROW - 1));
    assign x         = bus.inputVector;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (col_last && pass_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar i = 0; i < N_DSP48; i++) begin : g_lane
        int                             row;
        logic signed [BITWIDTH-1:0]     w;
        logic signed [BITWIDTH-1:0]     b;
        logic signed [2*BITWIDTH-1:0]   prod;
        logic signed [ACC_BITWIDTH-1:0] base;
        logic signed [ACC_BITWIDTH-1:0] rnd;

        assign row  = i * DSP48_PER_ROW + int'(row_mux);
        assign w    = bus.weightRow[row*BITWIDTH +: BITWIDTH];
        assign b    = bus.biasVector[row*BITWIDTH +: BITWIDTH];
        assign prod = w * x;

        // Column 0 restarts the lane from the bias, pre-aligned to the product's Q format.
        assign base = (col == '0)
                    ? ({{(ACC_BITWIDTH-BITWIDTH){b[BITWIDTH-1]}}, b} << QM)
                    : acc[i];
        assign lane_sum[i] = base + {{(ACC_BITWIDTH-2*BITWIDTH){prod[2*BITWIDTH-1]}}, prod};
        assign rnd         = (lane_sum[i] + RND_HALF) >>> QM;
        assign lane_sat[i] = (rnd > SAT_MAX) ? SAT_MAX[BITWIDTH-1:0]
                           : (rnd < SAT_MIN) ? SAT_MIN[BITWIDTH-1:0]
                           : rnd[BITWIDTH-1:0];
    end

    always_comb begin
        staging_next = staging;
        if (state == CALC && col_last) begin
            for (int i = 0; i < N_DSP48; i++) begin
                staging_next[(i*DSP48_PER_ROW + int'(row_mux))*BITWIDTH +: BITWIDTH] = lane_sat[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            row_mux <= '0;
            staging <= '0;
            out_vec <= '0;
            for (int i = 0; i < N_DSP48; i++) acc[i] <= '0;
        end else begin
            staging <= staging_next;
            if (state == CALC) begin
                col <= col + CW'(1);
                if (col_last) row_mux <= pass_last ? '0 : row_mux + PW'(1);
                for (int i = 0; i < N_DSP48; i++) acc[i] <= lane_sum[i];
                // The last pass lands in staging on this same edge, so publish the merged view.
                if (col_last && pass_last) out_vec <= staging_next;
            end else begin
                col     <= '0;
                row_mux <= '0;
            end
        end
    end

    assign bus.colAddress   = col;
    assign bus.busy         = (state == CALC);
    assign bus.dataReady    = (state == DONE);
    assign bus.outputVector = out_vec;
endmodule

// File: tb/tb_matvec_acc.sv
// Directed and randomized runs of matvec_acc (4x4, Q6.11, two rows per lane) against
// a plain-arithmetic model of y = sat(round(W*x + b)).
module tb_matvec_acc;
    localparam int NROW = 4;
    localparam int NCOL = 4;
    localparam int QN   = 6;
    localparam int QM   = 11;
    localparam int P    = 2;
    localparam int BW   = QN + QM + 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int wmem [NROW][NCOL];
    int xmem [NCOL];
    int bmem [NROW];

    matvec_acc_if #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) bus ();

    matvec_acc #(.NROW(NROW), .NCOL(NCOL), .QN(QN), .QM(QM), .DSP48_PER_ROW(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Zero-latency upstream memory addressed by colAddress.
    always_comb begin
        logic [NROW*BW-1:0] wr;
        logic [NROW*BW-1:0] bv;
        wr = '0;
        bv = '0;
        for (int r = 0; r < NROW; r++) begin
            wr[r*BW +: BW] = BW'(wmem[r][bus.colAddress]);
            bv[r*BW +: BW] = BW'(bmem[r]);
        end
        bus.weightRow   = wr;
        bus.biasVector  = bv;
        bus.inputVector = BW'(xmem[bus.colAddress]);
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint model(input int r);
        longint s;
        s = longint'(bmem[r]) * 2048;
        for (int c = 0; c < NCOL; c++) s += longint'(wmem[r][c]) * longint'(xmem[c]);
        s = (s + 1024) >>> 11;
        if (s > 131071)  s = 131071;
        if (s < -131072) s = -131072;
        return s;
    endfunction

    function automatic longint lane_out(input int r);
        logic signed [BW-1:0] v;
        v = bus.outputVector[r*BW +: BW];
        return longint'(v);
    endfunction

    task automatic set_uniform(input int w, input int x, input int b);
        for (int r = 0; r < NROW; r++) begin
            for (int c = 0; c < NCOL; c++) wmem[r][c] = w;
            bmem[r] = b;
        end
        for (int c = 0; c < NCOL; c++) xmem[c] = x;
    endtask

    task automatic set_random();
        for (int r = 0; r < NROW; r++) begin
            for (int c = 0; c < NCOL; c++) wmem[r][c] = int'($urandom_range(0, 262143)) - 131072;
            bmem[r] = int'($urandom_range(0, 262143)) - 131072;
        end
        for (int c = 0; c < NCOL; c++) xmem[c] = int'($urandom_range(0, 262143)) - 131072;
    endtask

    task automatic do_run(input string tag, input bit repulse);
        logic [NROW*BW-1:0] prev;
        int  cyc;
        int  busy_n;
        bit  col_ok;
        bit  hold_ok;
        bit  quiet;
        prev    = bus.outputVector;
        busy_n  = 0;
        col_ok  = 1'b1;
        hold_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.dataReady && cyc < 40) begin
            if (bus.busy) begin
                if (bus.colAddress != 2'(busy_n % NCOL)) col_ok = 1'b0;
                busy_n++;
            end
            if (bus.outputVector !== prev) hold_ok = 1'b0;
            bus.start = (repulse && cyc == 2);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, cyc, 9);
        chk({tag, " busy_cycles"}, busy_n, NCOL * P);
        chk({tag, " col_sequence"}, col_ok, 1);
        chk({tag, " output_hold"}, hold_ok, 1);
        for (int r = 0; r < NROW; r++) chk($sformatf("%s row%0d", tag, r), lane_out(r), model(r));
        @(negedge clk);
        chk({tag, " ready_pulse_width"}, bus.dataReady, 0);
        if (repulse) begin
            quiet = 1'b1;
            for (int i = 0; i < 12; i++) begin
                if (bus.dataReady || bus.busy) quiet = 1'b0;
                @(negedge clk);
            end
            chk({tag, " no_queued_run"}, quiet, 1);
        end
    endtask

    task automatic do_abort();
        bit quiet;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort busy_before", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", bus.busy, 0);
        chk("abort col", bus.colAddress, 0);
        chk("abort out", bus.outputVector, 0);
        chk("abort ready", bus.dataReady, 0);
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.dataReady || bus.busy) quiet = 1'b0;
        end
        chk("abort quiet", quiet, 1);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b1;
        set_uniform(0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset busy", bus.busy, 0);
        chk("reset ready", bus.dataReady, 0);
        chk("reset col", bus.colAddress, 0);
        chk("reset out", bus.outputVector, 0);
        bus.start = 1'b0;
        reset     = 1'b0;
        @(negedge clk);

        set_uniform(2048, 2048, 0);
        do_run("ones", 1'b0);
        chk("ones literal", lane_out(0), 8192);

        set_uniform(0, 2048, 1024);
        do_run("bias", 1'b0);
        chk("bias literal", lane_out(3), 1024);

        set_uniform(131071, 131071, 0);
        do_run("sat_pos", 1'b0);
        chk("sat_pos literal", lane_out(1), 131071);

        set_uniform(-131072, 131071, 0);
        do_run("sat_neg", 1'b0);
        chk("sat_neg literal", lane_out(2), -131072);

        set_uniform(1, 1024, 0);
        do_run("round", 1'b0);
        chk("round literal", lane_out(0), 2);

        for (int r = 0; r < NROW; r++) begin
            for (int c = 0; c < NCOL; c++) wmem[r][c] = (r + 1) * 512 + c * 100 - r * 37;
            bmem[r] = r * 300 - 400;
        end
        for (int c = 0; c < NCOL; c++) xmem[c] = 1500 - c * 700;
        do_run("distinct_repulse", 1'b1);

        do_abort();

        for (int n = 0; n < 6; n++) begin
            set_random();
            do_run($sformatf("rand%0d", n), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matvec_acc.md
MATVEC_ACC -- requirements
Module: matvec_acc

Interface
REQ-001 SHALL have parameter NROW, default 16: matrix rows (output vector length).
REQ-002 SHALL have parameter NCOL, default 16: matrix columns (input vector length); power of 2, minimum 2.
REQ-003 SHALL have parameter QN, default 6: integer bits of the signed fixed-point format.
REQ-004 SHALL have parameter QM, default 11: fraction bits; minimum 1.
REQ-005 SHALL have parameter DSP48_PER_ROW, default 2: rows time-shared per multiplier (P); power of 2; NROW divisible by P.
REQ-006 SHALL derive BITWIDTH = QN+QM+1, N_DSP48 = NROW/P, ACC_BITWIDTH = 2*BITWIDTH+log2(NCOL)+1.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: request a new matrix-vector product.
REQ-010 SHALL have port weightRow, input, NROW*BITWIDTH bits: column colAddress of the weight matrix; row r occupies bits [r*BITWIDTH +: BITWIDTH].
REQ-011 SHALL have port inputVector, input, BITWIDTH bits: element colAddress of the input vector.
REQ-012 SHALL have port biasVector, input, NROW*BITWIDTH bits: per-row bias; same packing as weightRow.
REQ-013 SHALL have port colAddress, output, log2(NCOL) bits: column currently requested from upstream memory.
REQ-014 SHALL have port busy, output, 1 bit: high during CALC.
REQ-015 SHALL have port dataReady, output, 1 bit: one-cycle pulse when outputVector updates.
REQ-016 SHALL have port outputVector, output, NROW*BITWIDTH bits: result y = W*x + b, packed like weightRow.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, DONE; transitions: IDLE->CALC when start=1; CALC->DONE after the last column of the last pass; DONE->IDLE unconditionally.
REQ-018 SHALL, in CALC, run P passes (rowMux 0..P-1), each sweeping colAddress 0..NCOL-1 with colAddress incrementing every cycle and wrapping to 0 as rowMux increments; CALC lasts exactly NCOL*P cycles.
REQ-019 SHALL sample weightRow, inputVector and biasVector in the same cycle colAddress is presented, i.e. upstream read has zero latency.
REQ-020 SHALL, in pass p, have lane i (0..N_DSP48-1) serve row i*P+p, forming a full-precision signed 2*BITWIDTH product of weight and input.
REQ-021 SHALL, at column 0 of each pass, load each lane accumulator with (bias sign-extended, shifted left QM) plus the product; on later columns it SHALL add the product to the accumulator.
REQ-022 SHALL, at the last column of each pass, round the final sum (add 2^(QM-1), arithmetic shift right QM), saturate it to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1], and store it into an internal staging register for row i*P+p.
REQ-023 SHALL copy the staging register to outputVector on the edge entering DONE; outputVector SHALL otherwise hold its previous value throughout CALC.
REQ-024 SHALL assert dataReady only in DONE; busy only in CALC.
REQ-025 SHALL place the first CALC cycle at k+1 and the DONE cycle at k+1+NCOL*P when start is sampled high at edge k in IDLE.
REQ-026 SHALL ignore start in CALC and DONE, with no queuing; start held high SHALL begin a new run at the first IDLE cycle.
REQ-027 SHALL hold colAddress at 0 in IDLE and DONE.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, force IDLE, colAddress=0, rowMux=0, busy=0, dataReady=0, outputVector=0, accumulators and staging=0, regardless of state.
REQ-029 SHALL give reset priority over start in the same cycle; an aborted run SHALL produce no dataReady pulse.

Verification (NROW=4, NCOL=4, QN=6, QM=11, P=2; 1.0 = 2048)
REQ-030 SHALL cover: all weights 2048, input 2048, bias 0, start pulse -> dataReady exactly 9 cycles after start edge, every output 8192.
REQ-031 SHALL cover: weights 0, bias 1024 all rows -> every output 1024; busy high for exactly 8 cycles.
REQ-032 SHALL cover: weights 131071, input 131071 -> outputs 131071; weights -131072, input 131071 -> outputs -131072 (saturation).
REQ-033 SHALL cover: weights 1, input 1024, bias 0 -> outputs 2 (rounding of 4096/2048 plus half-LSB).
REQ-034 SHALL cover: start re-pulsed at CALC cycle 2 -> ignored, single dataReady; reset at CALC cycle 3 -> next cycle IDLE, colAddress 0, outputVector 0, no dataReady.
REQ-035 SHALL cover: distinct weights per row with P=2 -> rows 0,2 (pass 0) and 1,3 (pass 1) match a software reference bit-exactly.
